// File: rtl/vector_pkg.sv
// Shared definitions for the vector display-list player: opcodes, command width, FSM states.
package vector_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned CMD_W   = OP_W + 2 * COORD_W;

    localparam logic [OP_W-1:0] OP_JUMP = 2'b00;
    localparam logic [OP_W-1:0] OP_DRAW = 2'b01;
    localparam logic [OP_W-1:0] OP_END  = 2'b10;
    localparam logic [OP_W-1:0] OP_NOP  = 2'b11;

    // READ covers the one-cycle latency of the command RAM
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_READ   = 3'd2,
        ST_DECODE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SETTLE = 3'd5
    } state_e;

    function automatic logic [CMD_W-1:0] make_cmd(input logic [OP_W-1:0]    op,
                                                  input logic [COORD_W-1:0] cx,
                                                  input logic [COORD_W-1:0] cy);
        return {op, cx, cy};
    endfunction

endpackage

// File: rtl/vector_cmd_ram.sv
// Command RAM: one write port, one synchronous read port; a same-address read returns old data.
module vector_cmd_ram #(
    parameter  int unsigned DEPTH  = 256,
    parameter  int unsigned WIDTH  = 26,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vector_list_player.sv
// Display-list sequencer: plays JUMP/DRAW commands from RAM as ready-paced strobes, looping as frames.
module vector_list_player #(
    parameter  int unsigned COORD_W = vector_pkg::COORD_W,
    parameter  int unsigned DEPTH   = 256,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned WORD_W  = 2 + 2 * COORD_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic               ready,
    output logic               draw,
    output logic               jump,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_done,
    output logic [15:0]        frame_cnt,
    output logic               busy
);

    import vector_pkg::*;

    localparam int unsigned        FCNT_W    = 16;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [OP_W-1:0]     op_q, op_n;
    logic [COORD_W-1:0]  x_n, y_n;
    logic                draw_n, jump_n, frame_done_n, busy_n;
    logic [FCNT_W-1:0]   frame_cnt_n;
    logic                wrap;
    logic                rd_en;
    logic [WORD_W-1:0]   rd_data;
    logic [OP_W-1:0]     rd_op;
    logic [COORD_W-1:0]  rd_x, rd_y;

    assign rd_op = rd_data[WORD_W-1 -: OP_W];
    assign rd_x  = rd_data[2*COORD_W-1 -: COORD_W];
    assign rd_y  = rd_data[COORD_W-1:0];

    vector_cmd_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (pc),
        .rd_data (rd_data)
    );

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        op_n         = op_q;
        x_n          = x;
        y_n          = y;
        draw_n       = 1'b0;
        jump_n       = 1'b0;
        frame_done_n = 1'b0;
        frame_cnt_n  = frame_cnt;
        wrap         = 1'b0;
        rd_en        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_en   = 1'b1;
                state_n = ST_READ;
            end
            ST_READ: begin
                state_n = ST_DECODE;
            end
            ST_DECODE: begin
                if (rd_op == OP_END) begin
                    wrap    = 1'b1;
                    state_n = run ? ST_FETCH : ST_IDLE;
                end else if (rd_op == OP_NOP) begin
                    wrap    = (pc == LAST_ADDR);
                    pc_n    = pc + ADDR_W'(1);
                    state_n = ST_FETCH;
                end else begin
                    op_n    = rd_op;
                    x_n     = rd_x;
                    y_n     = rd_y;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A latched command always completes, regardless of run
                if (ready) begin
                    draw_n  = (op_q == OP_DRAW);
                    jump_n  = (op_q == OP_JUMP);
                    wrap    = (pc == LAST_ADDR);
                    pc_n    = pc + ADDR_W'(1);
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_n = run ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (wrap) begin
            pc_n         = '0;
            frame_done_n = 1'b1;
            frame_cnt_n  = frame_cnt + FCNT_W'(1);
        end

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            op_q       <= OP_JUMP;
            x          <= '0;
            y          <= '0;
            draw       <= 1'b0;
            jump       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            op_q       <= op_n;
            x          <= x_n;
            y          <= y_n;
            draw       <= draw_n;
            jump       <= jump_n;
            frame_done <= frame_done_n;
            frame_cnt  <= frame_cnt_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_vector_list_player.sv
// Scoreboard bench for vector_list_player: expected strobes/frames are queued and matched at negedge.
module tb_vector_list_player;

    import vector_pkg::*;

    localparam int unsigned CW     = 12;
    localparam int unsigned DEPTH  = 256;
    localparam int          K_JUMP  = 0;
    localparam int          K_DRAW  = 1;
    localparam int          K_FRAME = 2;

    typedef struct {
        int            kind;
        logic [CW-1:0] ex;
        logic [CW-1:0] ey;
        int            fcnt;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             run;
    logic             wr_en;
    logic [7:0]       wr_addr;
    logic [CMD_W-1:0] wr_data;
    logic             ready = 1'b1;
    logic             draw;
    logic             jump;
    logic [CW-1:0]    x;
    logic [CW-1:0]    y;
    logic             frame_done;
    logic [15:0]      frame_cnt;
    logic             busy;

    ev_t exp_q[$];
    int  n_checks      = 0;
    int  n_fail        = 0;
    int  exp_fcnt      = 0;
    bit  ready_force   = 1'b0;
    int  rcnt          = 0;
    int  cyc           = 0;
    int  last_fd       = 0;
    bit  fd_seen       = 1'b0;
    bit  fd_period_chk = 1'b0;

    vector_list_player #(
        .COORD_W (CW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ready      (ready),
        .draw       (draw),
        .jump       (jump),
        .x          (x),
        .y          (y),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor, then the ready model: ready drops after a strobe for 10 cycles
    always @(negedge clk) begin : mon
        ev_t e;
        cyc++;
        if (reset_n) begin
            if (draw || jump) begin
                check("strobe_excl", 32'(draw & jump), 32'd0);
                check("strobe_ready", 32'(ready), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", draw ? 32'd1 : 32'd0, 32'(e.kind));
                    check("strobe_x", 32'(x), 32'(e.ex));
                    check("strobe_y", 32'(y), 32'(e.ey));
                end
            end
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_kind", 32'(K_FRAME), 32'(e.kind));
                    check("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
                end
                if (fd_period_chk && fd_seen) begin
                    check("frame_period", 32'(cyc - last_fd), 32'd3);
                end
                fd_seen = 1'b1;
                last_fd = cyc;
            end
        end
        if (ready_force) begin
            ready = 1'b0;
            rcnt  = 0;
        end else if (draw || jump) begin
            ready = 1'b0;
            rcnt  = 10;
        end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) ready = 1'b1;
        end else begin
            ready = 1'b1;
        end
    end

    task automatic push_ev(input int kind, input int px, input int py);
        ev_t e;
        e.kind = kind;
        e.ex   = CW'(px);
        e.ey   = CW'(py);
        e.fcnt = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_frame();
        ev_t e;
        exp_fcnt++;
        e.kind = K_FRAME;
        e.ex   = '0;
        e.ey   = '0;
        e.fcnt = exp_fcnt;
        exp_q.push_back(e);
    endtask

    task automatic push_square_frame();
        push_ev(K_JUMP, 4095, 400);
        push_ev(K_DRAW, 0, 3695);
        push_ev(K_DRAW, 4095, 4095);
        push_ev(K_DRAW, 0, 0);
        push_frame();
    endtask

    task automatic write_cmd(input int a, input logic [1:0] op, input int px, input int py);
        @(negedge clk); #1;
        wr_en   = 1'b1;
        wr_addr = 8'(a);
        wr_data = make_cmd(op, CW'(px), CW'(py));
        @(negedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic load_list(input bit with_nop);
        int a;
        a = 0;
        write_cmd(a, OP_JUMP, 4095, 400); a++;
        if (with_nop) begin
            write_cmd(a, OP_NOP, 7, 7); a++;
        end
        write_cmd(a, OP_DRAW, 0, 3695);    a++;
        write_cmd(a, OP_DRAW, 4095, 4095); a++;
        write_cmd(a, OP_DRAW, 0, 0);       a++;
        write_cmd(a, OP_END, 0, 0);
    endtask

    task automatic do_reset();
        run      = 1'b0;
        reset_n  = 1'b0;
        exp_fcnt = 0;
        repeat (2) @(negedge clk);
        #1;
        reset_n  = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_qsize(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (exp_q.size() > n && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        if (exp_q.size() > n) check(tag, 32'(exp_q.size()), 32'(n));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
        $fatal(1);
    end

    initial begin : main
        int i;
        reset_n = 1'b0;
        run     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        #1;
        check("rst_draw", 32'(draw), 32'd0);
        check("rst_jump", 32'(jump), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // Square list, two frames plus the first jump of the third
        load_list(1'b0);
        do_reset();
        push_square_frame();
        push_square_frame();
        push_ev(K_JUMP, 4095, 400);
        run = 1'b1;
        wait_qsize(0, 3000, "t1_drain");
        run = 1'b0;
        wait_cycles(30);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_frames", 32'(frame_cnt), 32'd2);

        // Ready held low while a jump waits
        do_reset();
        ready_force = 1'b1;
        run = 1'b1;
        wait_cycles(500);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_x_held", 32'(x), 32'd4095);
        check("t2_y_held", 32'(y), 32'd400);
        push_ev(K_JUMP, 4095, 400);
        run = 1'b0;
        ready_force = 1'b0;
        @(negedge clk); #1;
        check("t2_not_early", 32'(jump), 32'd0);
        @(negedge clk); #1;
        check("t2_strobe_next", 32'(jump), 32'd1);
        wait_qsize(0, 10, "t2_drain");
        wait_cycles(5);
        check("t2_idle", 32'(busy), 32'd0);

        // NOP at address 1 produces no strobe
        load_list(1'b1);
        do_reset();
        push_square_frame();
        push_ev(K_JUMP, 4095, 400);
        run = 1'b1;
        wait_qsize(0, 2000, "t3_nop_drain");
        run = 1'b0;
        wait_cycles(30);
        check("t3_nop_frames", 32'(frame_cnt), 32'd1);

        // Full RAM of draws, wrap after the last address
        for (int a = 0; a < 256; a++) write_cmd(a, OP_DRAW, a * 16, 4095 - a);
        do_reset();
        for (int a = 0; a < 256; a++) push_ev(K_DRAW, a * 16, 4095 - a);
        push_frame();
        run = 1'b1;
        wait_qsize(0, 8000, "t3_full_drain");
        run = 1'b0;
        wait_cycles(30);
        check("t3_full_frames", 32'(frame_cnt), 32'd1);
        check("t3_full_idle", 32'(busy), 32'd0);

        // Stop during WAIT of the 2nd command, then resume at the 3rd
        load_list(1'b0);
        do_reset();
        push_ev(K_JUMP, 4095, 400);
        run = 1'b1;
        wait_qsize(0, 100, "t4_jump");
        i = 0;
        while (x != 0 && i < 100) begin
            @(negedge clk); #1;
            i++;
        end
        check("t4_latched_y", 32'(y), 32'd3695);
        run = 1'b0;
        push_ev(K_DRAW, 0, 3695);
        wait_qsize(0, 100, "t4_draw2");
        wait_cycles(20);
        check("t4_idle", 32'(busy), 32'd0);
        push_ev(K_DRAW, 4095, 4095);
        run = 1'b1;
        wait_qsize(0, 100, "t4_resume");
        run = 1'b0;
        wait_cycles(20);
        check("t4_idle2", 32'(busy), 32'd0);

        // Empty list: frame every 3 cycles, no strobes
        write_cmd(0, OP_END, 0, 0);
        do_reset();
        fd_seen = 1'b0;
        fd_period_chk = 1'b1;
        repeat (21) push_frame();
        run = 1'b1;
        wait_qsize(1, 200, "t5_frames");
        run = 1'b0;
        wait_qsize(0, 20, "t5_last");
        wait_cycles(10);
        fd_period_chk = 1'b0;
        check("t5_frame_cnt", 32'(frame_cnt), 32'd21);
        check("t5_idle", 32'(busy), 32'd0);

        // Reset in the strobe cycle clears outputs at once; restart at address 0
        load_list(1'b0);
        do_reset();
        run = 1'b1;
        i = 0;
        while (!jump && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        check("t6_jump_issued", 32'(jump), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_jump_async", 32'(jump), 32'd0);
        check("t6_draw_async", 32'(draw), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_x_async", 32'(x), 32'd0);
        check("t6_y_async", 32'(y), 32'd0);
        exp_fcnt = 0;
        push_ev(K_JUMP, 4095, 400);
        push_ev(K_DRAW, 0, 3695);
        @(negedge clk); #1;
        reset_n = 1'b1;
        wait_qsize(0, 100, "t6_restart");
        run = 1'b0;
        wait_cycles(20);
        check("t6_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
